// File: rtl/risc_sequencer.sv
// 8-phase VeriRISC instruction sequencer: decodes opcode/zero into per-phase control strobes.
// Optional build macro CTRL_SINGLE_STEP_EN: hold in INST_ADDR until step is seen high.
//
// state      | meaning
// INST_ADDR  | phase 0, instruction address on the bus, all strobes low
// INST_FETCH | phase 1, instruction memory read
// INST_LOAD  | phase 2, instruction register captures the read data
// IDLE       | phase 3, instruction register load held
// OP_ADDR    | phase 4, PC increment; HLT leaves the loop from here
// OP_FETCH   | phase 5, operand memory read for ALU-type opcodes
// ALU_OP     | phase 6, accumulator load / SKZ skip / JMP load
// STORE      | phase 7, accumulator load, STO write, JMP completes; instruction retires
// HALTED     | sticky halt, phase reads 7, left only through rst_
module risc_sequencer #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [2:0]          opcode,
  input  logic                zero,
  input  logic                step,
  output logic                mem_rd,
  output logic                load_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                load_pc,
  output logic                load_ac,
  output logic                mem_wr,
  output logic [2:0]          phase,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                go;
  logic                aluop;

`ifdef CTRL_SINGLE_STEP_EN
  assign go = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign go          = 1'b1;
`endif

  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

  always_comb begin
    state_d = S_INST_ADDR;
    case (state_q)
      S_INST_ADDR:  state_d = go ? S_INST_FETCH : S_INST_ADDR;
      S_INST_FETCH: state_d = S_INST_LOAD;
      S_INST_LOAD:  state_d = S_IDLE;
      S_IDLE:       state_d = S_OP_ADDR;
      S_OP_ADDR:    state_d = (opcode == OP_HLT) ? S_HALTED : S_OP_FETCH;
      S_OP_FETCH:   state_d = S_ALU_OP;
      S_ALU_OP:     state_d = S_STORE;
      S_STORE:      state_d = S_INST_ADDR;
      S_HALTED:     state_d = S_HALTED;
      default:      state_d = S_INST_ADDR;
    endcase
  end

  // Only the STORE->INST_ADDR edge completes an instruction; HLT never gets there.
  assign retire_d = (state_q == S_STORE) ? retire_q + RETIRE_W'(1) : retire_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= S_INST_ADDR;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
    end
  end

  // Moore decode straight off the state register so reset clears the strobes immediately.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ac = 1'b0;
    mem_wr  = 1'b0;
    phase   = 3'd0;
    case (state_q)
      S_INST_ADDR: phase = 3'd0;
      S_INST_FETCH: begin
        phase  = 3'd1;
        mem_rd = 1'b1;
      end
      S_INST_LOAD: begin
        phase   = 3'd2;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      S_IDLE: begin
        phase   = 3'd3;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      S_OP_ADDR: begin
        phase  = 3'd4;
        inc_pc = 1'b1;
        halt   = (opcode == OP_HLT);
      end
      S_OP_FETCH: begin
        phase  = 3'd5;
        mem_rd = aluop;
      end
      S_ALU_OP: begin
        phase   = 3'd6;
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (opcode == OP_SKZ) && zero;
        load_pc = (opcode == OP_JMP);
      end
      S_STORE: begin
        // JMP raises load_pc and inc_pc together; the counter gives load priority.
        phase   = 3'd7;
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (opcode == OP_JMP);
        load_pc = (opcode == OP_JMP);
        mem_wr  = (opcode == OP_STO);
      end
      S_HALTED: begin
        phase = 3'd7;
        halt  = 1'b1;
      end
      default: phase = 3'd0;
    endcase
  end

  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed bench for risc_sequencer: two instances (RETIRE_W 16 and 2) share one stimulus.
// Define CTRL_SINGLE_STEP_EN for both files to also exercise single-step holding.
module tb_risc_sequencer;

  logic        clk = 1'b1;
  logic        rst_ = 1'b1;
  logic [2:0]  opcode = 3'd2;
  logic        zero = 1'b0;
  logic        step = 1'b1;

  logic        mem_rd_a, load_ir_a, halt_a, inc_pc_a, load_pc_a, load_ac_a, mem_wr_a;
  logic [2:0]  phase_a;
  logic [15:0] retire_a;
  logic        mem_rd_b, load_ir_b, halt_b, inc_pc_b, load_pc_b, load_ac_b, mem_wr_b;
  logic [2:0]  phase_b;
  logic [1:0]  retire_b;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;
  bit pulse_step = 1'b0;

  always #5 clk = ~clk;

  risc_sequencer #(.RETIRE_W(16)) u_dut_a (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .step(step),
    .mem_rd(mem_rd_a), .load_ir(load_ir_a), .halt(halt_a), .inc_pc(inc_pc_a),
    .load_pc(load_pc_a), .load_ac(load_ac_a), .mem_wr(mem_wr_a),
    .phase(phase_a), .retire_cnt(retire_a)
  );

  risc_sequencer #(.RETIRE_W(2)) u_dut_b (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .step(step),
    .mem_rd(mem_rd_b), .load_ir(load_ir_b), .halt(halt_b), .inc_pc(inc_pc_b),
    .load_pc(load_pc_b), .load_ac(load_ac_b), .mem_wr(mem_wr_b),
    .phase(phase_b), .retire_cnt(retire_b)
  );

  // {phase, mem_rd, load_ir, halt, inc_pc, load_pc, load_ac, mem_wr}
  wire [9:0] vec_a = {phase_a, mem_rd_a, load_ir_a, halt_a, inc_pc_a, load_pc_a, load_ac_a, mem_wr_a};
  wire [9:0] vec_b = {phase_b, mem_rd_b, load_ir_b, halt_b, inc_pc_b, load_pc_b, load_ac_b, mem_wr_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one instruction starting at a negedge in phase 0; masks are indexed by phase.
  // zero is driven inverted outside ALU_OP so only the phase-6 value may matter.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [7:0] mrd, input logic [7:0] inc,
                           input logic [7:0] lpc, input logic [7:0] lac,
                           input logic [7:0] mwr);
    logic [7:0] lir;
    logic [9:0] exp;
    lir    = 8'b0000_1100;
    opcode = op;
    for (int p = 0; p < 8; p++) begin
      zero = (p == 6) ? z : ~z;
      #1;
      exp = {3'(p), mrd[p], lir[p], 1'b0, inc[p], lpc[p], lac[p], mwr[p]};
      check($sformatf("%s_p%0d", tag, p), 32'(vec_a), 32'(exp));
      check($sformatf("%s_p%0d_b", tag, p), 32'(vec_b), 32'(exp));
      tick();
      if (p == 0 && pulse_step) step = 1'b0;
    end
    exp_ret++;
    check({tag, "_ret"}, 32'(retire_a), 32'(exp_ret & 32'hFFFF));
    check({tag, "_ret_b"}, 32'(retire_b), 32'(exp_ret & 32'h3));
  endtask

  initial begin
    #5 rst_ = 1'b0;
    #1;
    check("rst_async_vec", 32'(vec_a), 32'h0);
    check("rst_async_ret", 32'(retire_a), 32'h0);
    check("rst_async_ret_b", 32'(retire_b), 32'h0);
    @(negedge clk);
    rst_ = 1'b1;

    for (int i = 0; i < 4; i++)
      run_instr($sformatf("add%0d", i), 3'd2, 1'b0,
                8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000);

    run_instr("skz_z1", 3'd1, 1'b1, 8'b0000_1110, 8'b0101_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    run_instr("skz_z0", 3'd1, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
    run_instr("jmp",    3'd7, 1'b1, 8'b0000_1110, 8'b1001_0000, 8'b1100_0000, 8'b0000_0000, 8'b0000_0000);
    run_instr("sto",    3'd6, 1'b1, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b1000_0000);
    run_instr("and",    3'd3, 1'b1, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000);
    run_instr("xor",    3'd4, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000);
    run_instr("lda",    3'd5, 1'b1, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000);

`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("ss_hold%0d", i), 32'(vec_a), 32'h0);
    end
    pulse_step = 1'b1;
    step       = 1'b1;
    run_instr("ss_add", 3'd2, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000);
    pulse_step = 1'b0;
    tick();
    check("ss_after", 32'(vec_a), 32'h0);
    step = 1'b1;
`endif

    // HLT: normal fetch, halt with inc_pc in phase 4, then sticky HALTED.
    opcode = 3'd0;
    for (int p = 0; p < 5; p++) begin
      logic [7:0] mrd, lir, inc, hlt;
      mrd = 8'b0000_1110; lir = 8'b0000_1100; inc = 8'b0001_0000; hlt = 8'b0001_0000;
      check($sformatf("hlt_p%0d", p), 32'(vec_a),
            32'({3'(p), mrd[p], lir[p], hlt[p], inc[p], 3'b000}));
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      opcode = 3'(i);
      zero   = i[0];
      #1;
      check($sformatf("halted%0d", i), 32'(vec_a), 32'({3'd7, 7'b0010000}));
      tick();
    end
    check("halted_ret", 32'(retire_a), 32'(exp_ret & 32'hFFFF));
    check("halted_ret_b", 32'(retire_b), 32'(exp_ret & 32'h3));
    rst_ = 1'b0;
    #1;
    check("hlt_rst_vec", 32'(vec_a), 32'h0);
    check("hlt_rst_ret", 32'(retire_a), 32'h0);
    exp_ret = 0;
    @(negedge clk);
    rst_ = 1'b1;

    run_instr("post_hlt", 3'd2, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000);

    // Abort an ADD in ALU_OP: no partial retire, restart from phase 0.
    opcode = 3'd2;
    for (int i = 0; i < 6; i++) tick();
    check("abort_pre", 32'(phase_a), 32'd6);
    rst_ = 1'b0;
    #1;
    check("abort_vec", 32'(vec_a), 32'h0);
    check("abort_ret", 32'(retire_a), 32'h0);
    exp_ret = 0;
    @(negedge clk);
    rst_ = 1'b1;
    run_instr("post_abort", 3'd2, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1100_0000, 8'b0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
